// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 key-search dispatcher and its cracking cores.
package crack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_LEN,
    S_COPY,
    S_FOUND,
    S_FAIL
  } state_t;

  localparam int          KEY_W  = 24;
  localparam int          BYTE_W = 8;
  localparam logic [7:0]  PT_MIN = 8'h20;
  localparam logic [7:0]  PT_MAX = 8'h7E;

endpackage

// File: rtl/crack_winner_sel.sv
// Lowest-index priority encoder over the qualified per-core key_valid vector.
module crack_winner_sel #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/crack_dispatch.sv
// Starts all cracking cores, picks the winning core and copies its
// length-prefixed plaintext into the shared output memory.
module crack_dispatch #(
  parameter int NCORES = 2,
  parameter int KEY_W  = crack_pkg::KEY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    rdy,
  output logic                    done,
  output logic [KEY_W-1:0]        key,
  output logic                    key_valid,
  output logic [NCORES-1:0]       core_en,
  input  logic [NCORES-1:0]       core_rdy,
  input  logic [NCORES-1:0]       core_key_valid,
  input  logic [NCORES*KEY_W-1:0] core_key,
  output logic [7:0]              core_pt_addr,
  input  logic [NCORES*8-1:0]     core_pt_rddata,
  output logic [7:0]              pt_addr,
  output logic [7:0]              pt_wrdata,
  output logic                    pt_wren
);
  import crack_pkg::*;

  localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t              state, state_nx;
  logic [NCORES-1:0]   started;
  logic [IDX_W-1:0]    win_idx, sel_idx;
  logic                sel_found;
  logic [KEY_W-1:0]    key_r, sel_key;
  logic [BYTE_W-1:0]   len_r, win_byte;
  logic [8:0]          cnt, cnt_m1;
  logic                all_done, wr_cyc, last_wr;

  crack_winner_sel #(.N(NCORES), .IDX_W(IDX_W)) u_winner_sel (
    .req   (core_key_valid & started),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    sel_key  = '0;
    win_byte = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (sel_idx == IDX_W'(i)) sel_key  = core_key[i*KEY_W +: KEY_W];
      if (win_idx == IDX_W'(i)) win_byte = core_pt_rddata[i*8 +: 8];
    end
  end

  // Copy cycle 0 only re-reads address 0 and latches L; writes trail reads by one cycle.
  assign all_done = &(started & core_rdy);
  assign cnt_m1   = cnt - 9'd1;
  assign wr_cyc   = (state == S_COPY) && (cnt != '0);
  assign last_wr  = wr_cyc && (cnt_m1 == {1'b0, len_r});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (en) state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN: begin
        if (sel_found)     state_nx = S_LEN;
        else if (all_done) state_nx = S_FAIL;
      end
      S_LEN:   state_nx = S_COPY;
      S_COPY:  if (last_wr) state_nx = S_FOUND;
      S_FOUND: state_nx = S_FOUND;
      S_FAIL:  state_nx = S_FAIL;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started <= '0;
      win_idx <= '0;
      key_r   <= '0;
      len_r   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_START: started <= '0;
        S_RUN: begin
          started <= started | ~core_rdy;
          if (sel_found) begin
            win_idx <= sel_idx;
            key_r   <= sel_key;
          end
        end
        S_LEN:   cnt <= '0;
        S_COPY: begin
          if (cnt == '0) len_r <= win_byte;
          cnt <= cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy          = (state == S_IDLE);
    done         = (state == S_FOUND) || (state == S_FAIL);
    key_valid    = (state == S_FOUND);
    key          = (state == S_FOUND) ? key_r : '0;
    core_en      = (state == S_START) ? '1 : '0;
    core_pt_addr = (state == S_COPY) ? cnt[7:0] : 8'h00;
    pt_wren      = wr_cyc;
    pt_addr      = wr_cyc ? cnt_m1[7:0] : 8'h00;
    pt_wrdata    = wr_cyc ? win_byte : 8'h00;
  end

endmodule

// File: doc/crack_dispatch.md
Name: crack_dispatch

Overview:
- Top-level controller for the parallel ARC4 key search. Starts NCORES cracking cores together, each on an interleaved slice of the 24-bit key space, and watches their rdy/key_valid status.
- Picks the winning core and reports its key. Copies that core's length-prefixed plaintext into the shared output plaintext memory.
- Sits directly downstream of the cracking cores and upstream of the host/readout logic.

Parameters:
- NCORES, 2, number of cracking cores; core i gets key offset i and steps its key by NCORES.
- KEY_W, 24, key width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  block idle and able to accept en
- done  out  1  search finished, with key found or space exhausted
- key  out  KEY_W  winning key; valid while key_valid=1
- key_valid  out  1  a key was found and the plaintext copy is complete
- core_en  out  NCORES  one-cycle start pulse to every core
- core_rdy  in  NCORES  per-core rdy
- core_key_valid  in  NCORES  per-core key_valid
- core_key  in  NCORES*KEY_W  packed per-core keys; core i at [i*KEY_W +: KEY_W]
- core_pt_addr  out  8  read address broadcast to every core's plaintext port
- core_pt_rddata  in  NCORES*8  packed per-core plaintext read data; 1-cycle read latency
- pt_addr  out  8  output plaintext memory address
- pt_wrdata  out  8  output plaintext memory write data
- pt_wren  out  1  output plaintext memory write enable

Behaviour:
- Reset, clk edge with rst_n=0:
  - state IDLE; rdy=1; done=0; key_valid=0; key=0; core_en=0; pt_wren=0; core_pt_addr=0; internal counters and started bits cleared.
  - Reset takes effect from any state, including mid-copy. A partially written output memory is left as-is.
- States: IDLE, START, RUN, LEN, COPY, FOUND, FAIL.
- IDLE -> START when en=1. rdy=1 only in IDLE; en is ignored in all other states.
- START, one cycle:
  - core_en=all ones. Clears the per-core started bits. Goes to RUN.
- RUN:
  - started[i] sets when core_rdy[i]=0 is seen.
  - A core is finished when started[i]=1 and core_rdy[i]=1.
  - Winner = lowest index i with core_key_valid[i]=1 and started[i]=1. If several cores go valid in the same cycle, the lowest index wins.
  - Winner exists: latch its index and key -> LEN.
  - Else, all cores finished with key_valid=0 -> FAIL.
- LEN:
  - core_pt_addr=0. Next cycle latch L = winner's byte 0 and clear the 9-bit copy counter.
  - -> COPY.
- COPY:
  - Each cycle, read address = counter, 8 LSBs driven on core_pt_addr. Counter increments.
  - The data returned one cycle later is written to the output memory: pt_addr = counter-1, pt_wrdata = winner's rddata, pt_wren=1.
  - Exactly L+1 bytes are written (addresses 0..L), byte 0 = L.
  - Counter is 9 bits, so L=255 writes 256 bytes with no wrap. L=0 writes a single byte.
  - After the final write -> FOUND.
  - Copy time from entering LEN to FOUND is L+3 cycles.
- FOUND: done=1, key_valid=1, key=latched key. Terminal until rst_n.
- FAIL: done=1, key_valid=0, key=0. Terminal until rst_n.
- No core_key_valid is accepted from a core whose started bit is clear. This prevents a stale key_valid from a core that was never restarted.
- pt_wren=0 in every state except the write cycles of COPY.

Decomposition:
- Shared package crack_pkg: state enum, KEY_W, byte-width constant, readable-range constants 8'h20/8'h7E (shared with the cores).
- One natural sub-module: crack_winner_sel. Combinational lowest-index priority encoder over (core_key_valid & started), returning a found flag and the winner index.

Test Plan:
- NCORES=2 stub cores; core 1 asserts key_valid with key 24'h000003 after 50 cycles; its plaintext = {3,'a','b','c'} -> key=24'h000003, key_valid=1, done=1; output memory addresses 0..3 = 03,61,62,63 with exactly 4 pt_wren pulses.
- Cores 0 and 1 assert key_valid in the same cycle (keys 24'h000010 and 24'h000011) -> key=24'h000010; plaintext copied from core 0.
- Both cores drop rdy, then return rdy=1 with key_valid=0 -> FAIL: done=1, key_valid=0, key=0, no pt_wren pulses.
- Winner plaintext L=255 -> 256 writes, addresses 0x00..0xFF, last write data = winner byte 255, then FOUND. L=0 -> single write of 00 at address 0.
- Stub core holds key_valid=1 before start -> ignored until that core drops rdy after core_en; result is taken from the post-start report only.
- rst_n asserted mid-COPY -> next cycle rdy=1, done=0, pt_wren=0. A new en runs a full search to completion correctly.
